yuv_mb_pingpong_buffer: RTL



---
 rtl/yuv_mb_pkg.sv | 35 +++
 rtl/yuv_mb_bank_ram.sv | 27 ++
 rtl/yuv_mb_pingpong_buffer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/yuv_mb_pkg.sv
// Shared types and geometry helpers for the YUV macroblock ping-pong buffer.
// Default geometry plus helper functions that derive word counts and address
// widths from a given (IMG_WIDTH, BPW, MB_H) configuration.
package yuv_mb_pkg;

  localparam int DEF_IMG_WIDTH = 1280;
  localparam int DEF_BPW       = 4;
  localparam int DEF_MB_H      = 16;

  typedef enum logic {WR_FILL, WR_WAIT} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_Y, RD_UV, RD_DONE} rd_state_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int words_per_row(input int img_w, input int bpw);
    return img_w / bpw;
  endfunction

  function automatic int words_per_mbrow(input int bpw);
    return 16 / bpw;
  endfunction

  function automatic int mb_per_stripe(input int img_w);
    return img_w / 16;
  endfunction

  // Y and UV planes share the same per-bank depth (4:2:2 worst case for UV).
  function automatic int bank_words(input int img_w, input int bpw, input int mb_h);
    return mb_h * (img_w / bpw);
  endfunction

endpackage

// File: rtl/yuv_mb_bank_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
// The address MSB selects the ping-pong bank.
//   clk    : clock
//   we     : write enable, waddr/wdata : write address/data
//   re     : read enable,  raddr       : read address
//   rdata  : read data, valid the cycle after re, held until the next read
module yuv_mb_bank_ram #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/yuv_mb_pingpong_buffer.sv
// Two-bank stripe buffer between the camera byte stream and the H.264 front
// end. A 16-row stripe is captured into one bank while the other bank is read
// out macroblock by macroblock (all Y rows, then interleaved UV rows).
//   clk, rst           : clock, synchronous active-high reset
//   cfg_422            : 0 = 4:2:0 (YUYV/Y-only alternating rows), 1 = 4:2:2
//   w_data/w_valid/w_ready : input byte stream
//   o_data/o_valid/o_ready : output words, first pixel-order byte in the MSBs
//   o_sop/o_eop/o_eos  : first/last word of a macroblock, last word of stripe
//   bank_full          : per-bank full status
//
// state    | meaning
// WR_FILL  | accepting bytes into the write bank
// WR_WAIT  | write bank still full, w_ready low until the reader frees it
// RD_IDLE  | waiting for the read bank to fill; issues word 0 once it does
// RD_Y     | issuing luma words of the current macroblock
// RD_UV    | issuing interleaved chroma words of the current macroblock
// RD_DONE  | stripe drained: free the bank and flip to the other one
module yuv_mb_pingpong_buffer
  import yuv_mb_pkg::*;
#(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int BPW       = DEF_BPW,
  parameter int MB_H      = DEF_MB_H
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_422,
  input  logic [7:0]       w_data,
  input  logic             w_valid,
  output logic             w_ready,
  output logic [8*BPW-1:0] o_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_eos,
  output logic [1:0]       bank_full
);

  localparam int WPR = words_per_row(IMG_WIDTH, BPW);
  localparam int WPM = words_per_mbrow(BPW);
  localparam int MBS = mb_per_stripe(IMG_WIDTH);
  localparam int AW  = clog2_min1(bank_words(IMG_WIDTH, BPW, MB_H));
  localparam int RW  = clog2_min1(MB_H);
  localparam int CW  = clog2_min1(2 * IMG_WIDTH);
  localparam int MW  = clog2_min1(MBS);
  localparam int WW  = clog2_min1(WPM);
  localparam int DW  = 8 * BPW;

  // write side
  wr_state_t     wr_state;
  logic          wr_bank;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [DW-1:0] y_sh, uv_sh, y_next, uv_next;
  logic [4:0]    y_cnt, uv_cnt;
  logic [AW-1:0] y_waddr, uv_waddr;
  logic [1:0]    bank_422;
  logic [1:0]    bf_nxt;
  logic          w_acc, yonly_row, row_end, stripe_end, is_y, y_we, uv_we;

  // read side
  rd_state_t     rd_state;
  logic          rd_bank;
  logic [MW-1:0] rd_mb;
  logic [RW-1:0] rd_row;
  logic [WW-1:0] rd_w;
  logic [AW-1:0] rd_addr;
  logic          rd_422, rd_active, rd_uv, pop, issue, w_last, row_last, mb_last;
  logic [2:0]    occ;
  logic          pend, pend_uv, pend_sop, pend_eop, pend_eos;
  logic [DW-1:0] y_rdata, uv_rdata, rd_word;
  logic [DW-1:0] sk_data;
  logic          sk_valid, sk_sop, sk_eop, sk_eos;

  always_comb begin
    w_acc      = w_valid && w_ready;
    // Row 0 is always YUYV, so the not-yet-captured mode bit is harmless there.
    yonly_row  = wr_row[0] && !bank_422[wr_bank];
    row_end    = wr_col == (yonly_row ? CW'(IMG_WIDTH - 1) : CW'(2 * IMG_WIDTH - 1));
    stripe_end = w_acc && row_end && (wr_row == RW'(MB_H - 1));
    is_y       = yonly_row || !wr_col[0];
    y_next     = y_sh << 8;
    y_next[7:0] = w_data;
    uv_next    = uv_sh << 8;
    uv_next[7:0] = w_data;
    y_we       = w_acc && is_y && (y_cnt == 5'(BPW - 1));
    uv_we      = w_acc && !is_y && (uv_cnt == 5'(BPW - 1));
    // Look-ahead full flags let a same-cycle free release the writer at once.
    bf_nxt = bank_full;
    if (stripe_end) bf_nxt[wr_bank] = 1'b1;
    if (rd_state == RD_DONE) bf_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= WR_FILL;
      w_ready   <= 1'b1;
      wr_bank   <= 1'b0;
      wr_row    <= '0;
      wr_col    <= '0;
      y_cnt     <= '0;
      uv_cnt    <= '0;
      y_waddr   <= '0;
      uv_waddr  <= '0;
      bank_422  <= '0;
      bank_full <= '0;
    end else begin
      bank_full <= bf_nxt;
      if (w_acc) begin
        if (wr_row == '0 && wr_col == '0) bank_422[wr_bank] <= cfg_422;
        if (is_y) begin
          y_sh  <= y_next;
          y_cnt <= y_we ? 5'd0 : y_cnt + 5'd1;
        end else begin
          uv_sh  <= uv_next;
          uv_cnt <= uv_we ? 5'd0 : uv_cnt + 5'd1;
        end
        if (y_we) y_waddr <= y_waddr + 1'b1;
        if (uv_we) uv_waddr <= uv_waddr + 1'b1;
        if (row_end) begin
          wr_col <= '0;
          wr_row <= wr_row + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
      if (stripe_end) begin
        wr_row   <= '0;
        y_waddr  <= '0;
        uv_waddr <= '0;
        wr_bank  <= !wr_bank;
        wr_state <= bf_nxt[!wr_bank] ? WR_WAIT : WR_FILL;
        w_ready  <= !bf_nxt[!wr_bank];
      end else if (wr_state == WR_WAIT && !bf_nxt[wr_bank]) begin
        wr_state <= WR_FILL;
        w_ready  <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_422    = bank_422[rd_bank];
    rd_uv     = rd_state == RD_UV;
    rd_active = (rd_state == RD_Y) || rd_uv || (rd_state == RD_IDLE && bank_full[rd_bank]);
    pop       = o_valid && o_ready;
    // Words buffered or in flight after this cycle's pop; keep room for one more.
    occ       = 3'(o_valid) + 3'(sk_valid) + 3'(pend) - 3'(pop);
    issue     = rd_active && (occ <= 3'd1);
    w_last    = rd_w == WW'(WPM - 1);
    row_last  = rd_row == ((rd_uv && !rd_422) ? RW'(MB_H / 2 - 1) : RW'(MB_H - 1));
    mb_last   = rd_mb == MW'(MBS - 1);
    rd_addr   = AW'(rd_row) * AW'(WPR) + AW'(rd_mb) * AW'(WPM) + AW'(rd_w);
    rd_word   = pend_uv ? uv_rdata : y_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      rd_bank  <= 1'b0;
      rd_mb    <= '0;
      rd_row   <= '0;
      rd_w     <= '0;
      pend     <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_sop    <= 1'b0;
      o_eop    <= 1'b0;
      o_eos    <= 1'b0;
      sk_valid <= 1'b0;
    end else begin
      pend <= issue;
      if (issue) begin
        pend_uv  <= rd_uv;
        pend_sop <= !rd_uv && rd_row == '0 && rd_w == '0;
        pend_eop <= rd_uv && row_last && w_last;
        pend_eos <= rd_uv && row_last && w_last && mb_last;
        rd_state <= rd_uv ? RD_UV : RD_Y;
        if (!w_last) begin
          rd_w <= rd_w + 1'b1;
        end else begin
          rd_w <= '0;
          if (!row_last) begin
            rd_row <= rd_row + 1'b1;
          end else begin
            rd_row <= '0;
            if (!rd_uv) begin
              rd_state <= RD_UV;
            end else if (mb_last) begin
              rd_mb    <= '0;
              rd_state <= RD_DONE;
            end else begin
              rd_mb    <= rd_mb + 1'b1;
              rd_state <= RD_Y;
            end
          end
        end
      end
      if (rd_state == RD_DONE) begin
        rd_bank  <= !rd_bank;
        rd_state <= RD_IDLE;
      end

      // Two-entry output buffer: head drives the ports, sk catches the word
      // already in flight from the RAM when the consumer stalls.
      if (!o_valid) begin
        if (pend) begin
          o_data  <= rd_word;
          o_sop   <= pend_sop;
          o_eop   <= pend_eop;
          o_eos   <= pend_eos;
          o_valid <= 1'b1;
        end
      end else if (!sk_valid) begin
        if (pop && pend) begin
          o_data <= rd_word;
          o_sop  <= pend_sop;
          o_eop  <= pend_eop;
          o_eos  <= pend_eos;
        end else if (pop) begin
          o_valid <= 1'b0;
        end else if (pend) begin
          sk_data  <= rd_word;
          sk_sop   <= pend_sop;
          sk_eop   <= pend_eop;
          sk_eos   <= pend_eos;
          sk_valid <= 1'b1;
        end
      end else if (pop) begin
        o_data <= sk_data;
        o_sop  <= sk_sop;
        o_eop  <= sk_eop;
        o_eos  <= sk_eos;
        if (pend) begin
          sk_data <= rd_word;
          sk_sop  <= pend_sop;
          sk_eop  <= pend_eop;
          sk_eos  <= pend_eos;
        end else begin
          sk_valid <= 1'b0;
        end
      end
    end
  end

  yuv_mb_bank_ram #(.DW(DW), .AW(AW + 1)) u_y_ram (
    .clk   (clk),
    .we    (y_we),
    .waddr ({wr_bank, y_waddr}),
    .wdata (y_next),
    .re    (issue && !rd_uv),
    .raddr ({rd_bank, rd_addr}),
    .rdata (y_rdata)
  );

  yuv_mb_bank_ram #(.DW(DW), .AW(AW + 1)) u_uv_ram (
    .clk   (clk),
    .we    (uv_we),
    .waddr ({wr_bank, uv_waddr}),
    .wdata (uv_next),
    .re    (issue && rd_uv),
    .raddr ({rd_bank, rd_addr}),
    .rdata (uv_rdata)
  );

endmodule
